// File: rtl/divider_seq_if.sv
// Request/response bundle for the sequential divider.
// The consumer drives start and the operands; the divider returns status and results.
interface divider_seq_if #(
  parameter int word_width = 8
);
  logic                  start;
  logic [word_width-1:0] DIVIDEND;
  logic [word_width-1:0] DIVISOR;
  logic                  busy;
  logic                  done;
  logic [word_width-1:0] Q;
  logic [word_width-1:0] R;
  logic                  div_by_zero;

  modport master (
    output start, DIVIDEND, DIVISOR,
    input  busy, done, Q, R, div_by_zero
  );

  modport slave (
    input  start, DIVIDEND, DIVISOR,
    output busy, done, Q, R, div_by_zero
  );
endinterface

// File: rtl/divider_seq.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// A divide by zero bypasses the iteration and reports all-ones / dividend one cycle after acceptance.
module divider_seq #(
  parameter int word_width = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  divider_seq_if.slave bus
);
  localparam int CW = $clog2(word_width);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [word_width:0]   p_q, p_d;      // partial remainder
  logic [word_width-1:0] n_q, n_d;      // dividend shifter, fills with quotient bits
  logic [word_width-1:0] d_q, d_d;      // captured divisor
  logic [CW-1:0]         cnt_q, cnt_d;  // iterations still to run after the current one
  logic [word_width-1:0] q_q, q_d;
  logic [word_width-1:0] r_q, r_d;
  logic                  done_q, done_d;
  logic                  dbz_q, dbz_d;
  logic                  dz_pend_q, dz_pend_d;  // divide-by-zero accepted, result due next edge

  logic [word_width:0]   shifted;
  logic [word_width+1:0] diff;
  logic [word_width:0]   p_step;
  logic [word_width-1:0] n_step;

  // One restoring step: shift in the next dividend bit and subtract the divisor if it fits.
  always_comb begin
    shifted = {p_q[word_width-1:0], n_q[word_width-1]};
    diff    = {1'b0, shifted} - {2'b00, d_q};
    if (!diff[word_width+1]) begin
      p_step = diff[word_width:0];
      n_step = {n_q[word_width-2:0], 1'b1};
    end else begin
      p_step = shifted;
      n_step = {n_q[word_width-2:0], 1'b0};
    end
  end

  // Next-state logic: operand capture in IDLE, iteration and completion in RUN.
  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    n_d       = n_q;
    d_d       = d_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    r_d       = r_q;
    dbz_d     = dbz_q;
    dz_pend_d = dz_pend_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // Finish a pending divide-by-zero first; it reads the dividend captured last edge.
        if (dz_pend_q) begin
          done_d    = 1'b1;
          q_d       = '1;
          r_d       = n_q;
          dbz_d     = 1'b1;
          dz_pend_d = 1'b0;
        end
        if (bus.start) begin
          n_d = bus.DIVIDEND;
          if (bus.DIVISOR != '0) begin
            d_d     = bus.DIVISOR;
            p_d     = '0;
            cnt_d   = CW'(word_width - 1);
            state_d = RUN;
          end else begin
            dz_pend_d = 1'b1;
          end
        end
      end
      RUN: begin
        p_d = p_step;
        n_d = n_step;
        if (cnt_q == '0) begin
          q_d     = n_step;
          r_d     = p_step[word_width-1:0];
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset aborts any divide in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      p_q       <= '0;
      n_q       <= '0;
      d_q       <= '0;
      cnt_q     <= '0;
      q_q       <= '0;
      r_q       <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      dz_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      n_q       <= n_d;
      d_q       <= d_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      r_q       <= r_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      dz_pend_q <= dz_pend_d;
    end
  end

  assign bus.busy        = (state_q == RUN);
  assign bus.done        = done_q;
  assign bus.Q           = q_q;
  assign bus.R           = r_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_divider_seq.sv
// Bench for divider_seq: an 8-bit and a 4-bit instance checked every cycle against
// a cycle-count / arithmetic model, plus literal expectations from directed cases.
module tb_divider_seq;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  divider_seq_if #(.word_width(8)) if8();
  divider_seq_if #(.word_width(4)) if4();

  divider_seq #(.word_width(8)) dut8 (.clk(clk), .reset_n(reset_n), .bus(if8.slave));
  divider_seq #(.word_width(4)) dut4 (.clk(clk), .reset_n(reset_n), .bus(if4.slave));

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  bit checks_on = 1'b0;

  // Model: m_cnt = edges left until done (0 = idle), results precomputed with / and %.
  int m_cnt[2];
  bit m_pend[2];
  int m_pdvd[2];
  int m_rq[2];
  int m_rr[2];
  bit e_done[2];
  bit e_busy[2];
  bit e_dbz[2];
  int e_q[2];
  int e_r[2];
  int done_count[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_pend[k] = 0; m_pdvd[k] = 0; m_rq[k] = 0; m_rr[k] = 0;
      e_done[k] = 0; e_busy[k] = 0; e_dbz[k] = 0; e_q[k] = 0; e_r[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input int w, input bit st, input int dvd, input int dvs);
    e_done[k] = 1'b0;
    if (m_cnt[k] > 0) begin
      m_cnt[k]--;
      if (m_cnt[k] == 0) begin
        e_done[k] = 1'b1; e_q[k] = m_rq[k]; e_r[k] = m_rr[k]; e_dbz[k] = 1'b0;
      end
    end else begin
      if (m_pend[k]) begin
        e_done[k] = 1'b1; e_q[k] = (1 << w) - 1; e_r[k] = m_pdvd[k]; e_dbz[k] = 1'b1;
        m_pend[k] = 1'b0;
      end
      if (st) begin
        if (dvs != 0) begin
          m_cnt[k] = w; m_rq[k] = dvd / dvs; m_rr[k] = dvd % dvs;
        end else begin
          m_pend[k] = 1'b1; m_pdvd[k] = dvd;
        end
      end
    end
    e_busy[k] = (m_cnt[k] > 0);
  endtask

  always @(negedge reset_n) model_reset();

  // Step the model on each edge from the sampled inputs, then compare shortly after.
  always @(posedge clk) begin
    cyc++;
    if (reset_n) begin
      model_step(0, 8, if8.start, int'(if8.DIVIDEND), int'(if8.DIVISOR));
      model_step(1, 4, if4.start, int'(if4.DIVIDEND), int'(if4.DIVISOR));
    end
    #1;
    if (checks_on) begin
      chk("busy8", if8.busy, e_busy[0]);
      chk("done8", if8.done, e_done[0]);
      chk("q8",    if8.Q,    e_q[0]);
      chk("r8",    if8.R,    e_r[0]);
      chk("dbz8",  if8.div_by_zero, e_dbz[0]);
      chk("busy4", if4.busy, e_busy[1]);
      chk("done4", if4.done, e_done[1]);
      chk("q4",    if4.Q,    e_q[1]);
      chk("r4",    if4.R,    e_r[1]);
      chk("dbz4",  if4.div_by_zero, e_dbz[1]);
    end
    if (if8.done === 1'b1) done_count[0]++;
    if (if4.done === 1'b1) done_count[1]++;
  end

  // Directed 8-bit divide with literal expectations and measured latency.
  task automatic div8(input int dvd, input int dvs, input int xq, input int xr,
                      input int xdbz, input int xlat);
    int lat;
    @(negedge clk);
    if8.start = 1'b1; if8.DIVIDEND = 8'(dvd); if8.DIVISOR = 8'(dvs);
    @(negedge clk);
    if8.start = 1'b0; if8.DIVIDEND = 8'($urandom); if8.DIVISOR = 8'($urandom);
    lat = 0;
    while (if8.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("lat8", lat, xlat);
    chk("lit_q8", if8.Q, xq);
    chk("lit_r8", if8.R, xr);
    chk("lit_dbz8", if8.div_by_zero, xdbz);
  endtask

  initial begin
    int dc;
    int waited;
    if8.start = 0; if8.DIVIDEND = 0; if8.DIVISOR = 0;
    if4.start = 0; if4.DIVIDEND = 0; if4.DIVISOR = 0;
    done_count[0] = 0; done_count[1] = 0;
    model_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1 checks_on = 1'b1;
    chk("rst_q8", if8.Q, 0);
    chk("rst_busy8", if8.busy, 0);
    chk("rst_done8", if8.done, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    div8(100, 7, 14, 2, 0, 8);
    div8(255, 1, 255, 0, 0, 8);
    div8(5, 9, 0, 5, 0, 8);
    div8(255, 255, 1, 0, 0, 8);
    div8(77, 0, 255, 77, 1, 1);
    div8(10, 3, 3, 1, 0, 8);

    // A start pulse during RUN must be ignored: exactly one done, result of the first divide.
    dc = done_count[0];
    @(negedge clk); if8.start = 1; if8.DIVIDEND = 200; if8.DIVISOR = 10;
    @(negedge clk); if8.start = 0;
    repeat (2) @(negedge clk);
    if8.start = 1; if8.DIVIDEND = 9; if8.DIVISOR = 3;
    @(negedge clk); if8.start = 0;
    repeat (15) @(negedge clk);
    chk("ignored_dones", done_count[0] - dc, 1);
    chk("ignored_q", if8.Q, 20);
    chk("ignored_r", if8.R, 0);

    // Start held high: every completion reports 50/6 and a new divide follows.
    dc = done_count[0];
    @(negedge clk); if8.start = 1; if8.DIVIDEND = 50; if8.DIVISOR = 6;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (if8.done === 1'b1) begin
        chk("hold_q", if8.Q, 8);
        chk("hold_r", if8.R, 2);
      end
    end
    if8.start = 0;
    chk("hold_min_dones", (done_count[0] - dc) >= 3, 1);
    repeat (12) @(negedge clk);

    // Reset in the middle of a divide clears outputs at once and suppresses done.
    dc = done_count[0];
    @(negedge clk); if8.start = 1; if8.DIVIDEND = 100; if8.DIVISOR = 7;
    @(negedge clk); if8.start = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_q", if8.Q, 0);
    chk("abort_r", if8.R, 0);
    chk("abort_busy", if8.busy, 0);
    @(negedge clk) reset_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", done_count[0] - dc, 0);
    div8(100, 7, 14, 2, 0, 8);

    // Random traffic on the 8-bit unit; the per-cycle model does the checking.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if8.start    = ($urandom_range(0, 3) == 0);
      if8.DIVIDEND = 8'($urandom);
      if8.DIVISOR  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
    end
    @(negedge clk); if8.start = 0;
    repeat (12) @(negedge clk);

    // Exhaustive 4-bit sweep with arithmetic invariants on every result.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        @(negedge clk);
        if4.start = 1; if4.DIVIDEND = 4'(a); if4.DIVISOR = 4'(b);
        @(negedge clk);
        if4.start = 0; if4.DIVIDEND = 4'($urandom); if4.DIVISOR = 4'($urandom);
        waited = 0;
        while (if4.done !== 1'b1 && waited < 20) begin
          @(negedge clk);
          waited++;
        end
        chk("sweep_lat4", waited, (b == 0) ? 1 : 4);
        if (b != 0) begin
          chk("sweep_recon4", int'(if4.Q) * b + int'(if4.R), a);
          chk("sweep_rlt4", int'(if4.R) < b, 1);
          chk("sweep_dbz4", if4.div_by_zero, 0);
        end else begin
          chk("sweep_zq4", if4.Q, 15);
          chk("sweep_zr4", if4.R, a);
          chk("sweep_zdbz4", if4.div_by_zero, 1);
        end
      end
    end
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
